// File: rtl/posit_pkg.sv
// Shared types and constants for the posit decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package posit_pkg;

    // Decoder sequencing: one field is peeled off the word per state.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SIGN   = 3'd1,
        ST_REGIME = 3'd2,
        ST_EXP    = 3'd3,
        ST_FRAC   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Width of the signed regime value k for an n-bit posit.
    // k spans -(n-1)..n-2, so clog2(n) magnitude bits plus a sign bit.
    function automatic int kw_of(input int n);
        return $clog2(n) + 1;
    endfunction

    // Special encodings, right-aligned in a 64-bit container.
    // nar=0 gives the zero pattern, nar=1 gives NaR (MSB set, rest clear).
    function automatic logic [63:0] special_pattern(input int n, input logic nar);
        return nar ? (64'd1 << (n - 1)) : 64'd0;
    endfunction

endpackage

// File: rtl/posit_abs.sv
// Conditional two's-complement negation of an N-bit word.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module posit_abs #(
    parameter int N = 32
) (
    input  logic         neg,
    input  logic [N-1:0] in_word,
    output logic [N-1:0] abs_word
);

    localparam logic [N-1:0] ONE = N'(1);

    // Negative posits are decoded from their magnitude; positives pass through.
    always_comb begin
        abs_word = in_word;
        if (neg) begin
            abs_word = ~in_word + ONE;
        end
    end

endmodule

// File: rtl/posit_decoder_gen.sv
// Multi-cycle posit field decoder: sign, regime k, exponent, mantissa, zero/NaR.
// Latency: 2 edges to done for zero/NaR; otherwise SIGN + regime bits + EXP + FRAC + DONE.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module posit_decoder_gen
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 3,
    localparam int KW = kw_of(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  posit_num,
    output logic          busy,
    output logic          done,
    output logic          sign,
    output logic [KW-1:0] k,
    output logic [ES-1:0] exp_value,
    output logic [N-1:0]  mantissa,
    output logic          is_zero,
    output logic          is_nar
);

    localparam logic [63:0]   ZERO64   = special_pattern(N, 1'b0);
    localparam logic [63:0]   NAR64    = special_pattern(N, 1'b1);
    localparam logic [N-1:0]  ZERO_PAT = ZERO64[N-1:0];
    localparam logic [N-1:0]  NAR_PAT  = NAR64[N-1:0];
    // The regime can occupy at most every bit after the sign.
    localparam logic [KW-1:0] RUN_MAX  = KW'(N - 1);
    localparam logic [KW-1:0] ONE_KW   = KW'(1);

    state_t        state_q, state_d;
    logic [N-1:0]  sr_q, sr_d;
    logic [KW-1:0] run_q, run_d;
    logic          rbit_q, rbit_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sign_q, sign_d;
    logic [KW-1:0] k_q, k_d;
    logic [ES-1:0] exp_q, exp_d;
    logic [N-1:0]  mant_q, mant_d;
    logic          zero_q, zero_d;
    logic          nar_q, nar_d;
    logic [N-1:0]  abs_word;

    // A run of ones of length r encodes k = r-1; a run of zeros encodes k = -r.
    function automatic logic [KW-1:0] regime_k(input logic ones, input logic [KW-1:0] run);
        return ones ? (run - ONE_KW) : (~run + ONE_KW);
    endfunction

    posit_abs #(
        .N(N)
    ) u_abs (
        .neg      (sr_q[N-1]),
        .in_word  (sr_q),
        .abs_word (abs_word)
    );

    // Next-state and datapath: the shift register is consumed MSB first, zeros fill in.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        run_d   = run_q;
        rbit_d  = rbit_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sign_d  = sign_q;
        k_d     = k_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        zero_d  = zero_q;
        nar_d   = nar_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = posit_num;
                    run_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SIGN;
                end
            end

            ST_SIGN: begin
                sign_d = sr_q[N-1];
                if ((sr_q == ZERO_PAT) || (sr_q == NAR_PAT)) begin
                    // Special encodings carry no regime/exponent/fraction.
                    zero_d  = (sr_q == ZERO_PAT);
                    nar_d   = (sr_q == NAR_PAT);
                    k_d     = '0;
                    exp_d   = '0;
                    mant_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    zero_d  = 1'b0;
                    nar_d   = 1'b0;
                    // Drop the sign; the first regime bit sets the run polarity.
                    sr_d    = abs_word << 1;
                    rbit_d  = abs_word[N-2];
                    run_d   = '0;
                    state_d = ST_REGIME;
                end
            end

            ST_REGIME: begin
                sr_d = sr_q << 1;
                if (sr_q[N-1] == rbit_q) begin
                    run_d = run_q + ONE_KW;
                    // Run filled the whole word: no terminator to consume.
                    if (run_d == RUN_MAX) begin
                        k_d     = regime_k(rbit_q, run_d);
                        state_d = ST_EXP;
                    end
                end else begin
                    // Opposite bit terminates the run and is consumed here.
                    k_d     = regime_k(rbit_q, run_q);
                    state_d = ST_EXP;
                end
            end

            ST_EXP: begin
                exp_d   = sr_q[N-1 -: ES];
                sr_d    = sr_q << ES;
                state_d = ST_FRAC;
            end

            ST_FRAC: begin
                mant_d  = {1'b1, sr_q[N-1:1]};
                state_d = ST_DONE;
            end

            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            run_q   <= '0;
            rbit_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sign_q  <= 1'b0;
            k_q     <= '0;
            exp_q   <= '0;
            mant_q  <= '0;
            zero_q  <= 1'b0;
            nar_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            run_q   <= run_d;
            rbit_q  <= rbit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sign_q  <= sign_d;
            k_q     <= k_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            zero_q  <= zero_d;
            nar_q   <= nar_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sign      = sign_q;
    assign k         = k_q;
    assign exp_value = exp_q;
    assign mantissa  = mant_q;
    assign is_zero   = zero_q;
    assign is_nar    = nar_q;

endmodule

// File: tb/tb_posit_decoder_gen.sv
// Self-checking bench for posit_decoder_gen at N=32, ES=3.
// Directed vectors, randomized words against a reference decoder, busy/DONE/reset cases.
// Every wait on done is bounded by a cycle budget.
module tb_posit_decoder_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] posit_num;
    logic        busy;
    logic        done;
    logic        sign;
    logic [5:0]  k;
    logic [2:0]  exp_value;
    logic [31:0] mantissa;
    logic        is_zero;
    logic        is_nar;

    int n_assert = 0;
    int n_fail   = 0;

    posit_decoder_gen #(
        .N  (32),
        .ES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .posit_num (posit_num),
        .busy      (busy),
        .done      (done),
        .sign      (sign),
        .k         (k),
        .exp_value (exp_value),
        .mantissa  (mantissa),
        .is_zero   (is_zero),
        .is_nar    (is_nar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference decoder straight from the posit definition: strip sign, take |x|,
    // measure the regime run, then read ES exponent bits and the fraction.
    // e_lat is the fixed accept-to-done latency where one is pinned down, else -1.
    function automatic void model(input logic [31:0] p,
                                  output logic e_sign, output logic e_zero, output logic e_nar,
                                  output logic [5:0] e_k, output logic [2:0] e_exp,
                                  output logic [31:0] e_mant, output int e_lat);
        logic [31:0] v;
        logic [63:0] body;
        logic [63:0] rest;
        logic        r0;
        int          run;
        int          term;
        int          ki;
        e_sign = p[31];
        e_zero = (p == 32'h0000_0000);
        e_nar  = (p == 32'h8000_0000);
        e_k    = '0;
        e_exp  = '0;
        e_mant = '0;
        e_lat  = 2;
        if (!e_zero && !e_nar) begin
            v    = p[31] ? (32'd0 - p) : p;
            body = {v[30:0], 33'd0};
            r0   = body[63];
            run  = 0;
            while (run < 31 && body[63 - run] == r0) run++;
            term  = (run < 31) ? 1 : 0;
            ki    = r0 ? (run - 1) : -run;
            e_k   = 6'(ki);
            rest  = body << (run + term);
            e_exp = rest[63:61];
            e_mant = {1'b1, rest[60:30]};
            e_lat = (term == 1) ? -1 : (run + 4);
        end
    endfunction

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic check_fields(input string tag, input logic [31:0] p);
        logic es, ez, en;
        logic [5:0] ek;
        logic [2:0] ee;
        logic [31:0] em;
        int el;
        model(p, es, ez, en, ek, ee, em, el);
        chk({tag, "_sign"},  64'(sign),      64'(es));
        chk({tag, "_k"},     64'(k),         64'(ek));
        chk({tag, "_exp"},   64'(exp_value), 64'(ee));
        chk({tag, "_mant"},  64'(mantissa),  64'(em));
        chk({tag, "_flags"}, 64'({is_zero, is_nar}), 64'({ez, en}));
    endtask

    task automatic run_decode(input logic [31:0] p, input string tag);
        logic es, ez, en;
        logic [5:0] ek;
        logic [2:0] ee;
        logic [31:0] em;
        int el;
        int lat;
        model(p, es, ez, en, ek, ee, em, el);
        @(negedge clk);
        start     = 1'b1;
        posit_num = p;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(tag, lat);
        if (el >= 0) chk({tag, "_lat"}, 64'(lat), 64'(el));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check_fields(tag, p);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'({busy, done}), 64'd0);
        check_fields({tag, "_hold"}, p);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] w2;
        int          lat;

        // Reset state
        rst       = 1'b0;
        start     = 1'b0;
        posit_num = '0;
        #1 rst = 1'b1;
        #2;
        chk("reset_outputs", 64'({busy, done, sign, k, exp_value, mantissa, is_zero, is_nar}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        run_decode(32'h4000_0000, "one");
        run_decode(32'h0A00_0000, "k_neg3");
        run_decode(32'h0000_0000, "zero");
        run_decode(32'hC000_0000, "neg_one");
        run_decode(32'h8000_0000, "nar");
        run_decode(32'h7FFF_FFFF, "maxpos");
        run_decode(32'h0000_0001, "minpos");
        run_decode(32'hFFFF_FFFF, "minneg");
        run_decode(32'h8000_0001, "maxneg");
        run_decode(32'h5C00_0000, "exp_bits");

        // Randomized words, biased toward long regimes of both polarities
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            case (i % 3)
                0: w2 = w;
                1: w2 = w >> $urandom_range(0, 31);
                default: begin
                    w2 = ~(w >> $urandom_range(0, 31));
                    w2[31] = 1'b0;
                end
            endcase
            run_decode(w2, $sformatf("rnd%0d", i));
        end

        // start while busy is ignored
        @(negedge clk);
        start     = 1'b1;
        posit_num = 32'h0A00_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start     = 1'b1;
        posit_num = 32'h7FFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_ign", lat);
        check_fields("busy_ign", 32'h0A00_0000);
        @(posedge clk);
        #1;
        chk("busy_ign_idle", 64'({busy, done}), 64'd0);

        // start held through DONE: taken only in the following IDLE cycle
        @(negedge clk);
        start     = 1'b1;
        posit_num = 32'h4000_0000;
        @(posedge clk);
        #1;
        wait_done("hold_start", lat);
        chk("hold_start_idle_busy", 64'(busy), 64'd0);
        check_fields("hold_start_first", 32'h4000_0000);
        posit_num = 32'h0A00_0000;
        @(posedge clk);
        #1;
        chk("hold_start_reaccept", 64'({busy, done}), 64'b10);
        start = 1'b0;
        wait_done("hold_start2", lat);
        check_fields("hold_start_second", 32'h0A00_0000);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a long regime
        @(negedge clk);
        start     = 1'b1;
        posit_num = 32'h8000_0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midreset_async", 64'({busy, done, sign, k, exp_value, mantissa, is_zero, is_nar}), 64'd0);
        @(posedge clk);
        #1;
        chk("midreset_held", 64'({busy, done}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_decode(32'h0A00_0000, "post_reset");
        run_decode(32'h7FFF_FFFF, "post_reset_long");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
